io_responder: RTL and testbench
===============================

# io_responder

Memory-mapped I/O responder that sits on the CPU's `io_*` port bundle and serves as the far end of the CPU's MEM-stage I/O access. It decodes `io_addr`, returns read data combinationally on `io_din`, and applies write and read side effects on the clock edge. Board-facing logic covers:
- an LED register;
- a seven-segment output word with a ready/ack handshake;
- a button-strobed switch input with a valid flag;
- a free-running cycle counter.

## Interface
Parameters:
- `SW_W`, default 16: switch input width.
- `LED_W`, default 16: LED output width.
- `DB_CYCLES`, default 4: consecutive stable samples required to accept a button level.

Ports (all in `clk` domain):
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `io_addr` input 8: byte address from the CPU.
- `io_dout` input 32: CPU write data.
- `io_we` input 1: write strobe, one cycle per store.
- `io_rd` input 1: read strobe, one cycle per load.
- `io_din` output 32: read data to the CPU.
- `sw` input SW_W: raw switches, asynchronous.
- `btn` input 1: raw "enter" button, asynchronous.
- `led` output LED_W: LED register.
- `seg_data` output 32: display word.
- `seg_vld` output 1: display word pending.
- `seg_ack` input 1: display consumed the word, one-cycle pulse.

## Operation
Register map. Word addresses; `io_addr[1:0]` is ignored; unmapped addresses read 0 and ignore writes.
- 0x00 LED, write-only: `led <= io_dout[LED_W-1:0]`.
- 0x04 OUT_RDY, read-only: bit0 = `~seg_vld`.
- 0x08 IN_VLD, read-only: bit0 = `in_vld`.
- 0x0C OUT_DATA, write-only: `seg_data <= io_dout`; `seg_vld <= 1`.
- 0x10 IN_DATA, read-only: latched switch word, zero-extended. A read with `io_rd=1` clears `in_vld` at the next edge.
- 0x14 CNT, read/write: 32-bit cycle counter. It increments every cycle and wraps 0xFFFFFFFF to 0. A write loads `io_dout`, and the counter then increments from that value.
- 0x18 SW, read-only: live synchronized switches, zero-extended.

Input path:
- `sw` passes through a 2-flop synchronizer.
- `btn` passes through a 2-flop synchronizer, then the debounce filter. The debounced level changes only after DB_CYCLES consecutive equal synchronized samples.
- A debounced rising edge latches the synchronized `sw` into IN_DATA and sets `in_vld`.

Output handshake:
- `seg_vld` clears on `seg_ack`.
- Writing OUT_DATA while `seg_vld=1` overwrites the word. This is legal, and `seg_vld` stays 1.

Simultaneous events:
- Button edge and IN_DATA read in the same cycle: the read returns the old data; the new data is latched; `in_vld` ends 1 (set wins).
- OUT_DATA write and `seg_ack` in the same cycle: `seg_vld` ends 1 (write wins).
- `io_we` and `io_rd` both high is illegal from the CPU. If it occurs, both effects apply.

## Timing
- `io_din` is combinational from `io_addr` and register state. The path does not depend on `io_rd`. The value is valid in the same cycle, matching the CPU's combinational MEM-stage read.
- All register updates occur at `posedge clk`. A write is visible on a read of the same address in the next cycle.
- Counter read: returns the pre-increment value of that cycle.
- Button latency: the raw rising edge sets `in_vld` after 2 + DB_CYCLES cycles (±1 for sampling phase).
- Reset (async, immediate):
  - `led` = 0, `seg_data` = 0, `seg_vld` = 0;
  - `in_vld` = 0, IN_DATA = 0, CNT = 0;
  - synchronizers = 0, debounced level = 0, debounce count = 0.
- `io_din` then reflects the reset state.
- Reset mid-debounce discards the pending edge. Reset with `seg_vld=1` drops the word.

## Structure
- Shared package `io_map_pkg` holds the address constants: `IO_LED` = 0x00, `IO_OUT_RDY` = 0x04, `IO_IN_VLD` = 0x08, `IO_OUT_DATA` = 0x0C, `IO_IN_DATA` = 0x10, `IO_CNT` = 0x14, `IO_SW` = 0x18. The CPU-side test programs use the same package.
- One sub-module, `btn_debounce`: synchronizer, debounce counter and rising-edge pulse output. Parameter DB_CYCLES; ports `clk`, `rst`, `raw`, `level`, `rise`.
- The top level holds address decode, the registers and the read mux.

## Test plan
- Reset: assert `rst` mid-cycle → `led`=0, `seg_vld`=0, `io_din`=0 at 0x08/0x10/0x14 immediately, without waiting for a clock.
- LED write: `io_we`, addr 0x00, `io_dout`=0x0001A5A5 → `led`=0xA5A5 next cycle; reading 0x00 → 0.
- Output handshake:
  - write 0x0C data 0xDEADBEEF → `seg_data`=0xDEADBEEF, `seg_vld`=1, read 0x04 → 0;
  - pulse `seg_ack` → `seg_vld`=0, read 0x04 → 1;
  - OUT_DATA write in the same cycle as `seg_ack` → `seg_vld` stays 1.
- Button input:
  - `sw`=0x1234, raise `btn` for 10 cycles (DB_CYCLES=4) → `in_vld`=1 within 7 cycles;
  - read 0x10 → 0x00001234, and `in_vld`=0 next cycle;
  - a 2-cycle `btn` glitch → no `in_vld` set.
- Collision: button edge in the same cycle as a 0x10 read → `io_din` returns old data; IN_DATA updates; `in_vld`=1 after.
- Counter: write 0x14 data 0xFFFFFFFE, then read at +1 and +3 cycles → 0xFFFFFFFE and 0x00000000 (wrap).

Source files
------------

// File: rtl/io_map_pkg.sv
// Purpose : shared I/O register map for the io_responder and the CPU-side test programs.
// Latency : n/a (constants and a pure helper function only).
// Backpressure: n/a.
package io_map_pkg;

    localparam int IO_ADDR_W = 8;

    localparam logic [IO_ADDR_W-1:0] IO_LED      = 8'h00;
    localparam logic [IO_ADDR_W-1:0] IO_OUT_RDY  = 8'h04;
    localparam logic [IO_ADDR_W-1:0] IO_IN_VLD   = 8'h08;
    localparam logic [IO_ADDR_W-1:0] IO_OUT_DATA = 8'h0C;
    localparam logic [IO_ADDR_W-1:0] IO_IN_DATA  = 8'h10;
    localparam logic [IO_ADDR_W-1:0] IO_CNT      = 8'h14;
    localparam logic [IO_ADDR_W-1:0] IO_SW       = 8'h18;

    // Registers are word-addressed; the byte offset inside a word is ignored.
    function automatic logic [IO_ADDR_W-1:0] word_addr(input logic [IO_ADDR_W-1:0] addr);
        return {addr[IO_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose : 2-flop synchronizer plus debounce filter for a raw push button, with rising-edge pulse.
// Latency : level follows raw after 2 sync stages plus DB_CYCLES equal samples; rise pulses with the new level.
// Backpressure: none; the button is sampled every cycle.
//
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   raw      : asynchronous button input
//   level    : debounced button level
//   rise     : one-cycle pulse in the first cycle level reads high
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          raw_meta;
    logic          raw_sync;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with the
    // current debounced level; any agreeing sample restarts the count, so a
    // glitch shorter than DB_CYCLES never reaches the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_meta <= 1'b0;
            raw_sync <= 1'b0;
            level    <= 1'b0;
            rise     <= 1'b0;
            cnt      <= '0;
        end else begin
            raw_meta <= raw;
            raw_sync <= raw_meta;
            rise     <= 1'b0;
            if (raw_sync == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= raw_sync;
                rise  <= raw_sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// Purpose : memory-mapped I/O responder on the CPU io_* bundle: LED, display word, button-strobed switches, cycle counter.
// Latency : reads are combinational in the same cycle; writes and read side effects land on the next clk edge.
// Backpressure: none toward the CPU; the display side uses seg_vld/seg_ack and a new write simply overwrites a pending word.
//
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   io_addr/io_dout/io_we/io_rd    : CPU address, write data, write and read strobes
//   io_din                         : combinational read data to the CPU
//   sw, btn                        : raw asynchronous switches and enter button
//   led                            : LED register
//   seg_data/seg_vld/seg_ack       : display word, pending flag, consume pulse
module io_responder
    import io_map_pkg::*;
#(
    parameter int SW_W      = 16,
    parameter int LED_W     = 16,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       io_addr,
    input  logic [31:0]      io_dout,
    input  logic             io_we,
    input  logic             io_rd,
    output logic [31:0]      io_din,
    input  logic [SW_W-1:0]  sw,
    input  logic             btn,
    output logic [LED_W-1:0] led,
    output logic [31:0]      seg_data,
    output logic             seg_vld,
    input  logic             seg_ack
);

    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic [SW_W-1:0] in_data;
    logic            in_vld;
    logic [31:0]     cnt;

    logic            btn_level;
    logic            btn_rise;
    logic            btn_edge;

    logic [7:0]      waddr;
    logic            wr_led;
    logic            wr_out_data;
    logic            wr_cnt;
    logic            rd_in_data;

    logic [31:0]     sw_ext;
    logic [31:0]     in_data_ext;

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------
    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

    // rise only ever fires alongside a freshly-high level; qualifying on the
    // level keeps the latch tied to the button actually reading pressed.
    assign btn_edge = btn_rise & btn_level;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign waddr       = word_addr(io_addr);
    assign wr_led      = io_we & (waddr == IO_LED);
    assign wr_out_data = io_we & (waddr == IO_OUT_DATA);
    assign wr_cnt      = io_we & (waddr == IO_CNT);
    assign rd_in_data  = io_rd & (waddr == IO_IN_DATA);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else if (wr_led) begin
            led <= io_dout[LED_W-1:0];
        end
    end

    // A write in the same cycle as seg_ack wins: the new word is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_data <= '0;
            seg_vld  <= 1'b0;
        end else if (wr_out_data) begin
            seg_data <= io_dout;
            seg_vld  <= 1'b1;
        end else if (seg_ack) begin
            seg_vld  <= 1'b0;
        end
    end

    // A button edge coinciding with an IN_DATA read wins: the read sees the
    // old word, the new word is latched and stays flagged valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_data <= '0;
            in_vld  <= 1'b0;
        end else if (btn_edge) begin
            in_data <= sw_sync;
            in_vld  <= 1'b1;
        end else if (rd_in_data) begin
            in_vld  <= 1'b0;
        end
    end

    // Free-running counter; a load replaces this cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr_cnt) begin
            cnt <= io_dout;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, independent of io_rd)
    // ------------------------------------------------------------------
    always_comb begin
        sw_ext                 = '0;
        sw_ext[SW_W-1:0]       = sw_sync;
        in_data_ext            = '0;
        in_data_ext[SW_W-1:0]  = in_data;
    end

    always_comb begin
        io_din = '0;
        case (waddr)
            IO_OUT_RDY: io_din = {31'd0, ~seg_vld};
            IO_IN_VLD:  io_din = {31'd0, in_vld};
            IO_IN_DATA: io_din = in_data_ext;
            IO_CNT:     io_din = cnt;
            IO_SW:      io_din = sw_ext;
            default:    io_din = '0;
        endcase
    end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

    logic        clk;
    logic        rst;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;
    logic [15:0] sw;
    logic        btn;
    logic [15:0] led;
    logic [31:0] seg_data;
    logic        seg_vld;
    logic        seg_ack;

    int checks;
    int errors;

    io_responder #(
        .SW_W      (16),
        .LED_W     (16),
        .DB_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_dout  (io_dout),
        .io_we    (io_we),
        .io_rd    (io_rd),
        .io_din   (io_din),
        .sw       (sw),
        .btn      (btn),
        .led      (led),
        .seg_data (seg_data),
        .seg_vld  (seg_vld),
        .seg_ack  (seg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic        rd;
        logic        ack;
        logic [7:0]  addr;
        logic [31:0] dout;
        logic [31:0] exp_din;   // combinational, before the edge
        logic [15:0] exp_led;   // after the edge
        logic        exp_vld;
        logic [31:0] exp_seg;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        io_we   = 1'b0;
        io_rd   = 1'b0;
        seg_ack = 1'b0;
        io_dout = '0;
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        int hit;
        int old_reads;
        logic [31:0] last;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        io_addr = 8'h00;
        sw  = 16'h00AB;
        btn = 1'b0;
        idle();

        vecs[0]  = '{"led_wr",       1, 0, 0, 8'h00, 32'h0001A5A5, 32'h0, 16'hA5A5, 0, 32'h0};
        vecs[1]  = '{"led_rd_zero",  0, 1, 0, 8'h00, 32'h0,        32'h0, 16'hA5A5, 0, 32'h0};
        vecs[2]  = '{"out_wr",       1, 0, 0, 8'h0C, 32'hDEADBEEF, 32'h0, 16'hA5A5, 1, 32'hDEADBEEF};
        vecs[3]  = '{"rdy_busy",     0, 1, 0, 8'h04, 32'h0,        32'h0, 16'hA5A5, 1, 32'hDEADBEEF};
        vecs[4]  = '{"ack",          0, 0, 1, 8'h04, 32'h0,        32'h0, 16'hA5A5, 0, 32'hDEADBEEF};
        vecs[5]  = '{"rdy_free",     0, 1, 0, 8'h04, 32'h0,        32'h1, 16'hA5A5, 0, 32'hDEADBEEF};
        vecs[6]  = '{"out_wr2",      1, 0, 0, 8'h0C, 32'h11112222, 32'h0, 16'hA5A5, 1, 32'h11112222};
        vecs[7]  = '{"out_wr_ack",   1, 0, 1, 8'h0C, 32'h33334444, 32'h0, 16'hA5A5, 1, 32'h33334444};
        vecs[8]  = '{"ack2",         0, 0, 1, 8'h04, 32'h0,        32'h0, 16'hA5A5, 0, 32'h33334444};
        vecs[9]  = '{"unmapped_wr",  1, 0, 0, 8'h1C, 32'hFFFFFFFF, 32'h0, 16'hA5A5, 0, 32'h33334444};
        vecs[10] = '{"unmapped_rd",  0, 1, 0, 8'h1C, 32'h0,        32'h0, 16'hA5A5, 0, 32'h33334444};
        vecs[11] = '{"led_wr_byte3", 1, 0, 0, 8'h03, 32'h00005A5A, 32'h0, 16'h5A5A, 0, 32'h33334444};
        vecs[12] = '{"in_vld_idle",  0, 1, 0, 8'h08, 32'h0,        32'h0, 16'h5A5A, 0, 32'h33334444};
        vecs[13] = '{"in_data_idle", 0, 0, 0, 8'h10, 32'h0,        32'h0, 16'h5A5A, 0, 32'h33334444};
        vecs[14] = '{"sw_live",      0, 1, 0, 8'h1A, 32'h0,        32'h000000AB, 16'h5A5A, 0, 32'h33334444};

        // Power-on reset
        wait_neg(3);
        rst = 1'b0;
        #1;
        check("por_led", {16'h0, led}, 32'h0);
        check("por_seg_vld", {31'h0, seg_vld}, 32'h0);
        check("por_seg_data", seg_data, 32'h0);
        wait_neg(3);

        // Register map vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            io_we   = vecs[i].we;
            io_rd   = vecs[i].rd;
            seg_ack = vecs[i].ack;
            io_addr = vecs[i].addr;
            io_dout = vecs[i].dout;
            #1;
            check({vecs[i].name, "_din"}, io_din, vecs[i].exp_din);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_led"}, {16'h0, led}, {16'h0, vecs[i].exp_led});
            check({vecs[i].name, "_vld"}, {31'h0, seg_vld}, {31'h0, vecs[i].exp_vld});
            check({vecs[i].name, "_seg"}, seg_data, vecs[i].exp_seg);
        end
        @(negedge clk);
        idle();

        // Button press latches switches
        sw = 16'h1234;
        wait_neg(3);
        io_addr = 8'h08;
        btn = 1'b1;
        hit = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            #1;
            if (hit == 0 && io_din[0] === 1'b1) hit = c;
        end
        btn = 1'b0;
        checks++;
        if (hit < 5 || hit > 7) begin
            errors++;
            $display("FAIL btn_latency: got %0d cycles, expected 5..7", hit);
        end
        wait_neg(10);
        io_addr = 8'h10;
        io_rd = 1'b1;
        #1;
        check("in_data_read", io_din, 32'h00001234);
        @(negedge clk);
        io_rd = 1'b0;
        io_addr = 8'h08;
        #1;
        check("in_vld_cleared", io_din, 32'h0);

        // Two-cycle glitch must be filtered
        btn = 1'b1;
        wait_neg(2);
        btn = 1'b0;
        hit = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (io_din[0] === 1'b1) hit = 1;
        end
        check("glitch_ignored", hit, 0);

        // Button edge coinciding with an IN_DATA read
        sw = 16'h5678;
        wait_neg(3);
        io_addr = 8'h10;
        io_rd = 1'b1;
        btn = 1'b1;
        old_reads = 0;
        last = 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            last = io_din;
            if (io_din !== 32'h00001234) break;
            old_reads++;
        end
        io_rd = 1'b0;
        io_addr = 8'h08;
        #1;
        check("collide_new_data", last, 32'h00005678);
        checks++;
        if (old_reads < 4) begin
            errors++;
            $display("FAIL collide_old_data: got %0d old reads, expected at least 4", old_reads);
        end
        check("collide_in_vld", io_din, 32'h1);
        wait_neg(6);
        btn = 1'b0;
        wait_neg(8);

        // Counter load and wrap
        @(negedge clk);
        io_we = 1'b1;
        io_addr = 8'h14;
        io_dout = 32'hFFFFFFFE;
        @(negedge clk);
        idle();
        #1;
        check("cnt_plus1", io_din, 32'hFFFFFFFE);
        wait_neg(2);
        #1;
        check("cnt_plus3_wrap", io_din, 32'h00000000);

        // Asynchronous reset with live state
        @(negedge clk);
        io_we = 1'b1;
        io_addr = 8'h0C;
        io_dout = 32'hCAFEF00D;
        @(negedge clk);
        idle();
        io_addr = 8'h08;
        #1;
        check("pre_rst_in_vld", io_din, 32'h1);
        check("pre_rst_seg_vld", {31'h0, seg_vld}, 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_seg_vld", {31'h0, seg_vld}, 32'h0);
        check("rst_seg_data", seg_data, 32'h0);
        check("rst_in_vld", io_din, 32'h0);
        io_addr = 8'h10;
        #1;
        check("rst_in_data", io_din, 32'h0);
        io_addr = 8'h14;
        #1;
        check("rst_cnt", io_din, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_neg(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
